// File: rtl/alu_arbiter_ctrl.sv
// Two-requester round-robin arbiter and sequencer for the shared 8-bit ALU.
// Accepts one operation per IDLE, drives the ALU for one EXEC cycle, then holds a tagged response.
module alu_arbiter_ctrl #(
    parameter int unsigned OPS_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [3:0]           req0_op,
    input  logic [7:0]           req0_a,
    input  logic [7:0]           req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [3:0]           req1_op,
    input  logic [7:0]           req1_a,
    input  logic [7:0]           req1_b,
    output logic [3:0]           alu_sel,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    input  logic [15:0]          alu_c,
    input  logic                 alu_carry,
    input  logic                 alu_overflow,
    input  logic                 alu_negativo,
    input  logic                 alu_cero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [15:0]          rsp_c,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_err,
    output logic [OPS_CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] LAST_LEGAL_OP = 4'b1010;

    state_e                 state_q,      state_d;
    logic                   last_grant_q, last_grant_d;
    logic [3:0]             alu_sel_q,    alu_sel_d;
    logic [7:0]             alu_a_q,      alu_a_d;
    logic [7:0]             alu_b_q,      alu_b_d;
    logic                   rsp_valid_q,  rsp_valid_d;
    logic                   rsp_id_q,     rsp_id_d;
    logic [15:0]            rsp_c_q,      rsp_c_d;
    logic [3:0]             rsp_flags_q,  rsp_flags_d;
    logic                   rsp_err_q,    rsp_err_d;
    logic [OPS_CNT_W-1:0]   ops_done_q,   ops_done_d;

    logic grant0;
    logic grant1;
    logic [3:0] win_op;

    // With both requesters valid, the one that did not win last time gets the ALU.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant_q);
        grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end

    // Ready is masked while reset is asserted so no handshake is signalled that reset will discard.
    assign req0_ready = rst_n && (state_q == IDLE) && grant0;
    assign req1_ready = rst_n && (state_q == IDLE) && grant1;
    assign win_op     = req1_ready ? req1_op : req0_op;

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        alu_sel_d    = alu_sel_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_c_d      = rsp_c_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        ops_done_d   = ops_done_q;

        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    alu_sel_d    = win_op;
                    alu_a_d      = req1_ready ? req1_a : req0_a;
                    alu_b_d      = req1_ready ? req1_b : req0_b;
                    rsp_id_d     = req1_ready;
                    rsp_err_d    = (win_op > LAST_LEGAL_OP);
                    last_grant_d = req1_ready;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_c_d     = rsp_err_q ? 16'h0000 : alu_c;
                rsp_flags_d = rsp_err_q ? 4'b0001
                                        : {alu_carry, alu_overflow, alu_negativo, alu_cero};
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + OPS_CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates make every flop sample pre-edge values whatever the statement order.
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            alu_sel_q    <= 4'h0;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_c_q      <= 16'h0000;
            rsp_flags_q  <= 4'h0;
            rsp_err_q    <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_sel_q    <= alu_sel_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_c_q      <= rsp_c_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: a behavioural ALU, a transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, and a randomized run with occasional resets.
module tb_alu_arbiter_ctrl;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op, req1_op;
    logic [7:0]   req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   alu_sel;
    logic [7:0]   alu_a, alu_b;
    logic [15:0]  alu_c;
    logic         alu_carry, alu_overflow, alu_negativo, alu_cero;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0]  rsp_c;
    logic [3:0]   rsp_flags;
    logic [W-1:0] ops_done;

    always #5 clk = ~clk;

    alu_arbiter_ctrl #(.OPS_CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_negativo(alu_negativo), .alu_cero(alu_cero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .ops_done(ops_done)
    );

    // Stand-in ALU: returns {c, carry, overflow, negativo, cero}; illegal selectors give junk on purpose.
    function automatic logic [19:0] alu_fn(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] c;
        logic cy, ov;
        cy = 1'b0;
        ov = 1'b0;
        case (s)
            4'd0: begin c = 16'(a) + 16'(b); cy = c[8]; ov = (a[7] == b[7]) && (c[7] != a[7]); end
            4'd1: begin c = 16'(a) - 16'(b); cy = (a < b); ov = (a[7] != b[7]) && (c[7] != a[7]); end
            4'd2: c = 16'(a) * 16'(b);
            4'd3: c = {8'h00, a & b};
            4'd4: c = {8'h00, a | b};
            4'd5: c = {8'h00, a ^ b};
            4'd6: c = {8'h00, ~a};
            4'd7: begin c = 16'(a) << 1; cy = a[7]; end
            4'd8: begin c = {8'h00, a >> 1}; cy = a[0]; end
            4'd9: c = 16'(a) + 16'(b) + 16'd1;
            4'd10: c = {a, b};
            default: begin c = {b, a}; cy = 1'b1; ov = 1'b1; end
        endcase
        return {c, cy, ov, c[15], (c == 16'h0000)};
    endfunction

    logic [19:0] alu_out;
    assign alu_out = alu_fn(alu_sel, alu_a, alu_b);
    assign alu_c = alu_out[19:4];
    assign {alu_carry, alu_overflow, alu_negativo, alu_cero} = alu_out[3:0];

    // Expected response {err, c, flags} for an accepted operation.
    function automatic logic [20:0] exp_rsp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        if (op > 4'd10) return {1'b1, 16'h0000, 4'b0001};
        return {1'b0, alu_fn(op, a, b)};
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: at most one operation outstanding, tracked by cycles since its acceptance.
    typedef struct packed {
        logic       id;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } txn_t;

    txn_t        cur;
    int unsigned age     = 0;   // 0 none outstanding, 1 on the ALU, 2 response offered
    logic        last_id = 1'b1;
    int unsigned done    = 0;
    logic        acc0 = 1'b0, acc1 = 1'b0;
    logic        grant_q[$];
    logic [21:0] resp_q[$];

    always @(negedge clk) begin
        logic win, e0, e1;
        logic [20:0] er;
        win = (req0_valid && req1_valid) ? !last_id : req1_valid;
        e0  = rst_n && (age == 0) && (req0_valid || req1_valid) && !win;
        e1  = rst_n && (age == 0) && (req0_valid || req1_valid) && win;
        check("m_req0_ready", req0_ready, e0);
        check("m_req1_ready", req1_ready, e1);
        check("m_rsp_valid", rsp_valid, age == 2);
        check("m_ops_done", ops_done, done % (1 << W));
        if (age == 1) check("m_alu_drive", {alu_sel, alu_a, alu_b}, {cur.op, cur.a, cur.b});
        if (age == 2) begin
            er = exp_rsp(cur.op, cur.a, cur.b);
            check("m_rsp", {rsp_id, rsp_err, rsp_c, rsp_flags}, {cur.id, er});
        end
        acc0 = req0_ready;
        acc1 = req1_ready;
        if (req0_ready || req1_ready) grant_q.push_back(req1_ready);
        if (rst_n && rsp_valid && rsp_ready) resp_q.push_back({rsp_id, rsp_err, rsp_c, rsp_flags});
        if (!rst_n) begin
            age = 0; done = 0; last_id = 1'b1;
        end else if (age == 0) begin
            if (e0 || e1) begin
                cur = e1 ? txn_t'{1'b1, req1_op, req1_a, req1_b} : txn_t'{1'b0, req0_op, req0_a, req0_b};
                last_id = e1;
                age = 1;
            end
        end else if (age == 1) begin
            age = 2;
        end else if (rsp_ready) begin
            done++;
            age = 0;
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    // One operation with rsp_ready held high; checks the N / N+1 / N+2 timing along the way.
    task automatic do_op(input logic id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [20:0] rsp, output logic [W-1:0] cnt);
        int k;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        k = 0;
        do begin @(negedge clk); k++; end while (!(id ? req1_ready : req0_ready) && k < 20);
        check("op_accept", id ? req1_ready : req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("op_exec_no_rsp", rsp_valid, 0);
        check("op_exec_drive", {alu_sel, alu_a, alu_b}, {op, a, b});
        @(negedge clk);
        check("op_rsp_valid", rsp_valid, 1);
        check("op_rsp_id", rsp_id, id);
        rsp = {rsp_err, rsp_c, rsp_flags};
        @(negedge clk);
        cnt = ops_done;
    endtask

    initial begin
        logic [20:0]  r;
        logic [W-1:0] cnt;
        logic [W-1:0] held;
        int k;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = 4'h0; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_op = 4'h0; req1_a = 8'h00; req1_b = 8'h00;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {rsp_valid, req0_ready, req1_ready, rsp_id, rsp_err, rsp_flags}, 0);
        check("rst_alu", {alu_sel, alu_a, alu_b}, 0);
        check("rst_rsp_c", rsp_c, 0);
        check("rst_ops_done", ops_done, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single request: 0xFF + 0x01 carries out.
        do_op(1'b0, 4'd0, 8'hFF, 8'h01, r, cnt);
        check("single_rsp", r, {1'b0, 16'h0100, 4'b1000});
        check("single_cnt", cnt, 1);

        // Contention from reset: grants alternate starting with requester 0.
        @(posedge clk); #1;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 8'd12; req0_b = 8'd12;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 8'd5;  req1_b = 8'd7;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        grant_q.delete();
        resp_q.delete();
        k = 0;
        while (grant_q.size() < 4 && k < 40) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        k = 0;
        while (resp_q.size() < 4 && k < 40) begin @(negedge clk); k++; end
        check("cont_grant_count", grant_q.size(), 4);
        check("cont_resp_count", resp_q.size(), 4);
        if (grant_q.size() >= 4) check("cont_grants", {grant_q[0], grant_q[1], grant_q[2], grant_q[3]}, 4'b0101);
        if (resp_q.size() >= 2) begin
            check("cont_rsp0", resp_q[0], {1'b0, 1'b0, 16'd144, 4'b0000});
            check("cont_rsp1", resp_q[1], {1'b1, 1'b0, 16'hFFFE, 4'b1010});
        end

        // Back-pressure: response held, nothing accepted, counter frozen.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 8'd3; req0_b = 8'd4;
        k = 0;
        do begin @(negedge clk); k++; end while (!req0_ready && k < 20);
        check("bp_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 8'd1; req1_b = 8'd1;
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp_valid && k < 20);
        held = ops_done;
        repeat (5) begin
            check("bp_hold", {rsp_valid, rsp_id, rsp_err, rsp_c, rsp_flags}, {3'b100, 16'd7, 4'b0000});
            check("bp_ready", {req0_ready, req1_ready}, 0);
            check("bp_cnt", ops_done, held);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_release", {rsp_valid, ops_done}, {1'b0, W'(held + 1'b1)});

        // Illegal opcode, then a legal one from the same requester.
        do_op(1'b1, 4'b1100, 8'd3, 8'd4, r, cnt);
        check("illegal_rsp", r, {1'b1, 16'h0000, 4'b0001});
        do_op(1'b1, 4'd0, 8'd1, 8'd2, r, cnt);
        check("after_illegal_rsp", r, {1'b0, 16'd3, 4'b0000});

        // Reset during EXEC discards the operation.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 8'd10; req0_b = 8'd20;
        k = 0;
        do begin @(negedge clk); k++; end while (!req0_ready && k < 20);
        check("midrst_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ctrl", {rsp_valid, req0_ready, req1_ready, rsp_id, rsp_err, rsp_flags}, 0);
        check("midrst_alu", {alu_sel, alu_a, alu_b}, 0);
        check("midrst_data", {rsp_c, ops_done}, 0);
        repeat (3) begin @(negedge clk); check("midrst_no_rsp", rsp_valid, 0); end
        do_op(1'b1, 4'd1, 8'd9, 8'd4, r, cnt);
        check("midrst_next_rsp", r, {1'b0, 16'd5, 4'b0000});
        check("midrst_next_cnt", cnt, 1);

        // Counter wrap with a 2-bit counter: 1,2,3,0,1.
        pulse_reset();
        do_op(1'b0, 4'd0, 8'h01, 8'h01, r, cnt); check("wrap_1", cnt, 1);
        do_op(1'b1, 4'd2, 8'h03, 8'h03, r, cnt); check("wrap_2", cnt, 2);
        do_op(1'b0, 4'd5, 8'hAA, 8'h55, r, cnt); check("wrap_3", cnt, 3);
        check("xor_rsp", r, {1'b0, 16'h00FF, 4'b0000});
        do_op(1'b1, 4'd0, 8'h80, 8'h80, r, cnt); check("wrap_0", cnt, 0);
        check("add_ovf_rsp", r, {1'b0, 16'h0100, 4'b1100});
        do_op(1'b0, 4'd1, 8'h00, 8'h00, r, cnt); check("wrap_1b", cnt, 1);
        check("sub_zero_rsp", r, {1'b0, 16'h0000, 4'b0001});

        // Randomized traffic; requesters hold their operation until accepted.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 299) != 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            if (!(req0_valid && !acc0)) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_op = 4'($urandom_range(0, 15));
                req0_a = 8'($urandom);
                req0_b = 8'($urandom);
            end
            if (!(req1_valid && !acc1)) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_op = 4'($urandom_range(0, 15));
                req1_a = 8'($urandom);
                req1_b = 8'($urandom);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter_ctrl.md
# alu_arbiter_ctrl

Two-requester arbiter and sequencer for the shared 8-bit ALU (4-bit selector, 8-bit A/B, 16-bit C, carry/overflow/negativo/cero flags). It accepts operation requests over valid/ready handshakes and grants the ALU round-robin. It drives the registered selector and operands to the combinational ALU, captures result and flags, and returns a tagged response over a valid/ready handshake. It sits between the instruction-issue logic and the ALU instance.

## Interface
- OPS_CNT_W, 16, width of the completed-operation counter (wraps)
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- req0_valid / req1_valid  in  1  requester 0/1 has an operation pending
- req0_ready / req1_ready  out  1  requester 0/1 operation accepted this cycle
- req0_op / req1_op  in  4  ALU selector code requested
- req0_a / req1_a, req0_b / req1_b  in  8  operands
- alu_sel  out  4  selector driven to the ALU
- alu_a, alu_b  out  8  operands driven to the ALU
- alu_c  in  16  ALU result
- alu_carry, alu_overflow, alu_negativo, alu_cero  in  1  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that issued the operation (0/1)
- rsp_c  out  16  captured result
- rsp_flags  out  4  {carry, overflow, negativo, cero} captured
- rsp_err  out  1  opcode was illegal (4'b1011–4'b1111)
- ops_done  out  OPS_CNT_W  count of responses consumed

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant one requester. reqN_ready = (state==IDLE) && grantN, combinationally. On handshake, register op/a/b, id and err = (op > 4'b1010). Go to EXEC.
- Arbitration: round-robin on last_grant. If only one requester is valid, it wins. If both are valid, the requester ≠ last_grant wins. last_grant updates on each handshake.
- EXEC (exactly 1 cycle): alu_sel/alu_a/alu_b come from registers and are stable for the whole cycle. At the end of EXEC, capture alu_c and the flags into rsp_c/rsp_flags. If err, force rsp_c=0 and rsp_flags=4'b0001 (cero=1). Go to RESP.
- RESP: rsp_valid=1. rsp_id/rsp_c/rsp_flags/rsp_err hold stable until rsp_ready. On rsp_valid&&rsp_ready, ops_done increments (wraps at 2^OPS_CNT_W to 0) and the FSM goes to IDLE.
- No request is accepted outside IDLE; both ready outputs are 0 in EXEC and RESP.
- A requester must hold op/a/b stable while valid and not ready. The block does not check this.
- The block does no arithmetic of its own. ALU results pass through unmodified except for illegal opcodes.
- Reset values: state=IDLE, last_grant=1 (requester 0 favoured first), alu_sel=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_id=0, rsp_c=0, rsp_flags=0, rsp_err=0, ops_done=0, req0_ready=req1_ready=0.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded with no response and the counter is cleared.

## Timing
- Handshake accepted in cycle N (IDLE). ALU is driven in cycle N+1 (EXEC). rsp_valid rises in cycle N+2.
- If rsp_ready=1 in N+2, the response is consumed that cycle, IDLE is reached in N+3, and the next accept can occur in N+3.
- Maximum throughput: one operation per 3 cycles. Back-pressure on rsp_ready stretches RESP indefinitely.
- The ALU path is combinational within EXEC; the captured values reflect the operands registered at N.
- Starvation-free: with both requesters continuously valid, grants strictly alternate.

## Test plan
- Single request: req0 op=0000, a=8'hFF, b=8'h01, rsp_ready=1 → req0_ready in cycle N; rsp_valid in N+2 with rsp_id=0, rsp_c=16'h0100, rsp_flags=1000 (carry); ops_done=1.
- Contention: both valid continuously after reset, req0 op=0010 a=12 b=12, req1 op=0001 a=5 b=7 → grants 0,1,0,1. Responses are 144/flags 0000 (id 0) and 16'hFFFE/flags 1010 (carry, negativo; id 1).
- Back-pressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid and data held stable, both ready outputs stay 0, ops_done unchanged until the handshake.
- Illegal opcode: req1 op=1100, a=3, b=4 → rsp_err=1, rsp_c=0, rsp_flags=0001, rsp_id=1; the next legal op completes normally.
- Reset mid-op: rst_n low during EXEC → next cycle all outputs at reset values, no response emitted. A new request after reset completes with the normal N+2 latency.
- Counter wrap: with OPS_CNT_W=2, run 5 operations → ops_done reads 1,2,3,0,1.
